// File: rtl/soc_bus_pkg.sv
// Shared types and constants for the SDRAM-window bus cache.
// Holds the controller state encoding, bus widths and the tag-width helper.
package soc_bus_pkg;

    localparam int ADDR_W = 32;
    localparam int DATA_W = 32;

    typedef enum logic [2:0] {
        FLUSH,
        IDLE,
        LOOKUP,
        FILL,
        WRITE,
        DONE
    } state_t;

    // Tag is whatever remains of the address above the index and the byte offset.
    function automatic int tag_width(input int index_bits);
        return ADDR_W - index_bits - 2;
    endfunction

endpackage

// File: rtl/bus_cache_ram.sv
// Line storage for bus_cache: one {valid, tag, data} entry per line.
// Synchronous read (one cycle latency) and a single write port on one clock.
module bus_cache_ram
    import soc_bus_pkg::*;
#(
    parameter int LINES = 256,
    parameter int TAG_W = 22,
    localparam int INDEX_BITS = $clog2(LINES)
) (
    input  logic                  clock,
    input  logic [INDEX_BITS-1:0] rd_index,
    output logic                  rd_valid,
    output logic [TAG_W-1:0]      rd_tag,
    output logic [DATA_W-1:0]     rd_data,
    input  logic                  wr_en,
    input  logic [INDEX_BITS-1:0] wr_index,
    input  logic                  wr_valid,
    input  logic [TAG_W-1:0]      wr_tag,
    input  logic [DATA_W-1:0]     wr_data
);

    typedef struct packed {
        logic              valid;
        logic [TAG_W-1:0]  tag;
        logic [DATA_W-1:0] data;
    } line_t;

    line_t mem [LINES];
    line_t rd_entry;

    // Write the addressed line when enabled and register the read entry every cycle.
    always_ff @(posedge clock) begin
        if (wr_en) begin
            mem[wr_index] <= '{valid: wr_valid, tag: wr_tag, data: wr_data};
        end
        rd_entry <= mem[rd_index];
    end

    assign rd_valid = rd_entry.valid;
    assign rd_tag   = rd_entry.tag;
    assign rd_data  = rd_entry.data;

endmodule

// File: rtl/bus_cache.sv
// Direct-mapped, write-through, no-write-allocate word cache in front of SDRAM.
// Optional hit/miss counters are built when BUS_CACHE_STATS_EN is defined.
module bus_cache
    import soc_bus_pkg::*;
#(
    parameter int LINES = 256,
    localparam int INDEX_BITS = $clog2(LINES)
) (
    input  logic              i_clock,
    input  logic              i_reset_n,
    input  logic              i_request,
    input  logic              i_rw,
    input  logic [ADDR_W-1:0] i_address,
    input  logic [DATA_W-1:0] i_wdata,
    output logic [DATA_W-1:0] o_rdata,
    output logic              o_ready,
    input  logic              i_flush,
    output logic              o_bus_request,
    output logic              o_bus_rw,
    output logic [ADDR_W-1:0] o_bus_address,
    output logic [DATA_W-1:0] o_bus_wdata,
    input  logic [DATA_W-1:0] i_bus_rdata,
    input  logic              i_bus_ready
`ifdef BUS_CACHE_STATS_EN
    ,
    output logic [31:0]       o_hits,
    output logic [31:0]       o_misses
`endif
);

    localparam int TAG_W = tag_width(INDEX_BITS);

    state_t                state;
    logic [INDEX_BITS:0]   flush_count;
    logic [INDEX_BITS:0]   flush_next;
    logic                  flush_pending;
    logic                  req_rw;
    logic [ADDR_W-1:0]     req_address;
    logic [DATA_W-1:0]     req_wdata;
    logic [INDEX_BITS-1:0] req_index;
    logic [TAG_W-1:0]      req_tag;

    logic                  line_valid;
    logic [TAG_W-1:0]      line_tag;
    logic [DATA_W-1:0]     line_data;
    logic                  line_hit;

    logic                  wr_en;
    logic [INDEX_BITS-1:0] wr_index;
    logic                  wr_valid;
    logic [TAG_W-1:0]      wr_tag;
    logic [DATA_W-1:0]     wr_data;

    assign req_index  = req_address[INDEX_BITS+1:2];
    assign req_tag    = req_address[ADDR_W-1:INDEX_BITS+2];
    assign line_hit   = line_valid && (line_tag == req_tag);
    assign flush_next = flush_count + 1'b1;

    // The line read is launched every cycle from the live CPU address so that
    // the entry is ready in LOOKUP, one cycle after IDLE accepts the request.
    bus_cache_ram #(
        .LINES (LINES),
        .TAG_W (TAG_W)
    ) u_ram (
        .clock    (i_clock),
        .rd_index (i_address[INDEX_BITS+1:2]),
        .rd_valid (line_valid),
        .rd_tag   (line_tag),
        .rd_data  (line_data),
        .wr_en    (wr_en),
        .wr_index (wr_index),
        .wr_valid (wr_valid),
        .wr_tag   (wr_tag),
        .wr_data  (wr_data)
    );

    // Select the single line write: flush clear, write-hit update or fill.
    always_comb begin
        wr_en    = 1'b0;
        wr_index = req_index;
        wr_valid = 1'b0;
        wr_tag   = req_tag;
        wr_data  = req_wdata;
        if (i_reset_n) begin
            case (state)
                FLUSH: begin
                    wr_en    = 1'b1;
                    wr_index = flush_count[INDEX_BITS-1:0];
                    wr_tag   = '0;
                    wr_data  = '0;
                end
                LOOKUP: begin
                    if (req_rw && line_hit) begin
                        wr_en    = 1'b1;
                        wr_valid = 1'b1;
                    end
                end
                FILL: begin
                    if (i_bus_ready) begin
                        wr_en    = 1'b1;
                        wr_valid = 1'b1;
                        wr_data  = i_bus_rdata;
                    end
                end
                default: begin
                    wr_en = 1'b0;
                end
            endcase
        end
    end

    // Controller: flush sweep, request acceptance, lookup, SDRAM transfer and CPU handshake.
    always_ff @(posedge i_clock) begin
        if (!i_reset_n) begin
            state         <= FLUSH;
            flush_count   <= '0;
            flush_pending <= 1'b0;
            req_rw        <= 1'b0;
            req_address   <= '0;
            req_wdata     <= '0;
            o_rdata       <= '0;
            o_ready       <= 1'b0;
            o_bus_request <= 1'b0;
            o_bus_rw      <= 1'b0;
            o_bus_address <= '0;
            o_bus_wdata   <= '0;
`ifdef BUS_CACHE_STATS_EN
            o_hits        <= '0;
            o_misses      <= '0;
`endif
        end else begin
            if (i_flush && (state != IDLE)) begin
                flush_pending <= 1'b1;
            end
            case (state)
                FLUSH: begin
                    flush_count <= flush_next;
                    if (flush_next[INDEX_BITS]) begin
                        state <= IDLE;
                    end
                end
                IDLE: begin
                    if (i_flush || flush_pending) begin
                        state         <= FLUSH;
                        flush_count   <= '0;
                        flush_pending <= 1'b0;
`ifdef BUS_CACHE_STATS_EN
                        o_hits        <= '0;
                        o_misses      <= '0;
`endif
                    end else if (i_request && !i_bus_ready) begin
                        req_rw      <= i_rw;
                        req_address <= i_address;
                        req_wdata   <= i_wdata;
                        state       <= LOOKUP;
                    end
                end
                LOOKUP: begin
                    if (req_rw) begin
                        o_bus_request <= 1'b1;
                        o_bus_rw      <= 1'b1;
                        o_bus_address <= req_address;
                        o_bus_wdata   <= req_wdata;
                        state         <= WRITE;
                    end else if (line_hit) begin
                        o_rdata <= line_data;
                        o_ready <= 1'b1;
                        state   <= DONE;
`ifdef BUS_CACHE_STATS_EN
                        o_hits  <= o_hits + 1'b1;
`endif
                    end else begin
                        o_bus_request <= 1'b1;
                        o_bus_rw      <= 1'b0;
                        o_bus_address <= req_address;
                        state         <= FILL;
`ifdef BUS_CACHE_STATS_EN
                        o_misses      <= o_misses + 1'b1;
`endif
                    end
                end
                FILL: begin
                    if (i_bus_ready) begin
                        o_rdata       <= i_bus_rdata;
                        o_bus_request <= 1'b0;
                        o_ready       <= 1'b1;
                        state         <= DONE;
                    end
                end
                WRITE: begin
                    if (i_bus_ready) begin
                        o_bus_request <= 1'b0;
                        o_ready       <= 1'b1;
                        state         <= DONE;
                    end
                end
                DONE: begin
                    if (!i_request) begin
                        o_ready <= 1'b0;
                        state   <= IDLE;
                    end
                end
                default: begin
                    state       <= FLUSH;
                    flush_count <= '0;
                end
            endcase
        end
    end

endmodule

// File: doc/bus_cache.md
Name: bus_cache

Overview:
- Direct-mapped, write-through, no-write-allocate word cache between the CPU data bus and the SDRAM interface.
- Sits downstream of the CPU address decode, on the 0x2000_0000–0x3FFF_FFFF SDRAM window, and upstream of the SDRAM controller.
- Uses the same request/rw/ready bus protocol on both sides.
- Reduces SDRAM read latency for repeated accesses.

Parameters:
- LINES, 256, number of cache lines (one 32-bit word each); power of two, ≥2.
- INDEX_BITS, $clog2(LINES), derived; not overridden.

Ports:
- i_clock  in  1  system clock
- i_reset_n  in  1  synchronous active-low reset
- i_request  in  1  CPU-side request, held until o_ready seen
- i_rw  in  1  1=write, 0=read
- i_address  in  32  byte address, window-relative; bits [1:0] ignored
- i_wdata  in  32  write data
- o_rdata  out  32  read data, valid while o_ready=1
- o_ready  out  1  transaction complete
- i_flush  in  1  pulse: invalidate all lines
- o_bus_request  out  1  SDRAM-side request
- o_bus_rw  out  1  SDRAM-side direction
- o_bus_address  out  32  SDRAM-side address (i_address passed through)
- o_bus_wdata  out  32  SDRAM-side write data
- i_bus_rdata  in  32  SDRAM read data
- i_bus_ready  in  1  SDRAM ready

Behaviour:
- Reset values: o_ready=0, o_rdata=0, o_bus_request=0, o_bus_rw=0, o_bus_address=0, o_bus_wdata=0.
- Reset enters FLUSH.
- Address split:
  - index = i_address[INDEX_BITS+1:2]
  - tag = i_address[31:INDEX_BITS+2]
  - each line stores valid, tag and data.
- Line memory is synchronous-read (1-cycle latency) with a single write port.
- FLUSH:
  - Writes valid=0 to index 0..LINES-1, one per cycle (LINES cycles), then goes to IDLE.
  - o_ready stays 0 throughout; requests stall.
  - i_flush pulsed in IDLE enters FLUSH; in any other state it is latched and honoured on return to IDLE.
- IDLE:
  - Waits for i_request=1 and i_bus_ready=0, then latches rw/address/wdata and issues the line read → LOOKUP.
- LOOKUP, hit means valid && tag match:
  - Read hit → DONE with o_rdata=line data. o_ready rises 2 cycles after i_request is sampled.
  - Read miss → FILL.
  - Write, hit or miss → WRITE. On a hit the line data is updated in the same cycle; a miss leaves the line unchanged.
- FILL:
  - o_bus_request=1, o_bus_rw=0 until i_bus_ready=1.
  - On that cycle: capture i_bus_rdata into o_rdata, write the line (valid=1, tag, data), drop o_bus_request → DONE.
- WRITE:
  - o_bus_request=1, o_bus_rw=1, o_bus_wdata=latched wdata until i_bus_ready=1.
  - Then drop o_bus_request → DONE.
- DONE:
  - o_ready=1 and o_rdata held while i_request=1.
  - When i_request=0: o_ready=0 next cycle → IDLE.
- Bus-side ordering:
  - A new SDRAM request is never issued while i_bus_ready is still high from the previous transaction; IDLE waits for it.
  - At most one outstanding SDRAM transaction.
- Reset asserted mid-transaction: the next edge forces all outputs to reset values and drops o_bus_request immediately. The pending CPU transaction is abandoned, and FLUSH restarts from index 0.
- LINES wrap: the flush counter is INDEX_BITS+1 wide and terminates when the MSB sets; no aliasing.

Optional Feature:
- BUS_CACHE_STATS_EN defined:
  - Adds outputs o_hits[31:0] and o_misses[31:0].
  - Read hit increments o_hits; read miss increments o_misses; writes count nothing.
  - Both counters clear on reset and on flush, and wrap at 2^32.
- Undefined: the ports and counters are absent; all other behaviour is identical.

Decomposition:
- Package soc_bus_pkg holds:
  - state enum {FLUSH, IDLE, LOOKUP, FILL, WRITE, DONE}
  - bus width constants: ADDR_W=32, DATA_W=32
  - function computing tag width from INDEX_BITS.
- One sub-module, bus_cache_ram:
  - LINES-deep single-clock RAM of {valid, tag, data}
  - registered read port, single write port.

Test Plan:
- Reset then poll: after reset release o_ready=0 for 256 cycles (LINES=256); a request at cycle 10 completes only after the flush ends.
- Read 0x00000100 miss (SDRAM returns 0xDEADBEEF after 5 cycles) → one SDRAM read, o_rdata=0xDEADBEEF. Repeat the read → no o_bus_request, o_ready 2 cycles after request.
- Write 0x00000100=0x12345678 with the line cached → SDRAM write issued with that data. A subsequent read returns 0x12345678 with no SDRAM access.
- Conflict: read 0x00000100, then read 0x00000500 (same index, LINES=256) → both miss. Re-reading 0x00000100 misses again.
- i_flush pulse after a cached read → the next read of the same address issues an SDRAM read. With BUS_CACHE_STATS_EN, counters read hits=0, misses=1 after that read.
- i_reset_n low during FILL with o_bus_request=1 → o_bus_request=0 on the next edge, o_ready=0, flush restarts.
